// File: rtl/twd_alloc_sequencer.sv
// twd_alloc_sequencer
//  Per-controller sequencer sitting between the command decoder and the shared
//  2D transaction queue. One command is in flight at a time:
//   - 1D commands go straight to ISSUE.
//   - 2D commands request a queue slot (ALLOC), write their descriptor into it
//     (WRITE), then issue the transfer tagged with the slot address (ISSUE).
//  All outputs are decoded from the state register or taken from registered
//  command/slot fields, so there is no combinational input-to-output path.
//  Optional feature macro: TWD_SEQ_STATS_EN adds saturating statistics counters
//  (stat_twd_cnt_o, stat_stall_cnt_o).
module twd_alloc_sequencer #(
  parameter int TRANS_WIDTH         = 64,
  parameter int TWD_QUEUE_WIDTH     = 2,
  parameter int TWD_QUEUE_DEPTH     = 4,
  parameter int TWD_QUEUE_ADD_WIDTH = $clog2(TWD_QUEUE_DEPTH)
`ifdef TWD_SEQ_STATS_EN
  ,
  parameter int STAT_CNT_WIDTH      = 16
`endif
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic                           cmd_twd_i,
  input  logic [TRANS_WIDTH-1:0]         cmd_dat_i,
  input  logic [TWD_QUEUE_WIDTH-1:0]     cmd_twd_dat_i,
  output logic                           alloc_req_o,
  input  logic                           alloc_gnt_i,
  input  logic [TWD_QUEUE_ADD_WIDTH-1:0] alloc_add_i,
  output logic                           wr_req_o,
  output logic [TWD_QUEUE_ADD_WIDTH-1:0] wr_add_o,
  output logic [TWD_QUEUE_WIDTH-1:0]     wr_dat_o,
  output logic                           trans_valid_o,
  input  logic                           trans_ready_i,
  output logic [TRANS_WIDTH-1:0]         trans_dat_o,
  output logic                           trans_twd_o,
  output logic [TWD_QUEUE_ADD_WIDTH-1:0] trans_twd_add_o,
  output logic                           busy_o
`ifdef TWD_SEQ_STATS_EN
  ,
  output logic [STAT_CNT_WIDTH-1:0]      stat_twd_cnt_o,
  output logic [STAT_CNT_WIDTH-1:0]      stat_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    WRITE = 2'd2,
    ISSUE = 2'd3
  } state_e;

  state_e                           state_r;
  state_e                           state_s;
  logic [TRANS_WIDTH-1:0]           dat_r;
  logic                             twd_r;
  logic [TWD_QUEUE_WIDTH-1:0]       desc_r;
  logic [TWD_QUEUE_ADD_WIDTH-1:0]   slot_r;
  logic                             accept_s;
  logic                             grant_s;
  logic                             done_s;
  logic                             in_alloc_s;
  logic                             in_write_s;
  logic                             in_issue_s;

  // State register; reset abandons any in-flight slot and returns to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus the capture/grant/handshake strobes.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    grant_s  = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid_i) begin
          accept_s = 1'b1;
          state_s  = cmd_twd_i ? ALLOC : ISSUE;
        end else begin
          state_s  = IDLE;
        end
      end
      ALLOC: begin
        // The request is held until granted; a full queue stalls us here.
        if (alloc_gnt_i) begin
          grant_s = 1'b1;
          state_s = WRITE;
        end else begin
          state_s = ALLOC;
        end
      end
      WRITE: begin
        state_s = ISSUE;
      end
      ISSUE: begin
        if (trans_ready_i) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = ISSUE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Command capture at acceptance; the descriptor is kept only for 2D commands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dat_r  <= {TRANS_WIDTH{1'b0}};
      twd_r  <= 1'b0;
      desc_r <= {TWD_QUEUE_WIDTH{1'b0}};
    end else if (accept_s) begin
      dat_r  <= cmd_dat_i;
      twd_r  <= cmd_twd_i;
      desc_r <= cmd_twd_i ? cmd_twd_dat_i : {TWD_QUEUE_WIDTH{1'b0}};
    end
  end

  // Slot address: cleared on every new command so 1D transfers report slot 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_r <= {TWD_QUEUE_ADD_WIDTH{1'b0}};
    end else if (accept_s) begin
      slot_r <= {TWD_QUEUE_ADD_WIDTH{1'b0}};
    end else if (grant_s) begin
      slot_r <= alloc_add_i;
    end
  end

  assign in_alloc_s = (state_r == ALLOC);
  assign in_write_s = (state_r == WRITE);
  assign in_issue_s = (state_r == ISSUE);

  assign cmd_ready_o     = (state_r == IDLE);
  assign busy_o          = (state_r != IDLE);
  assign alloc_req_o     = in_alloc_s;
  assign wr_req_o        = in_write_s;
  assign wr_add_o        = in_write_s ? slot_r : {TWD_QUEUE_ADD_WIDTH{1'b0}};
  assign wr_dat_o        = in_write_s ? desc_r : {TWD_QUEUE_WIDTH{1'b0}};
  assign trans_valid_o   = in_issue_s;
  assign trans_dat_o     = in_issue_s ? dat_r : {TRANS_WIDTH{1'b0}};
  assign trans_twd_o     = in_issue_s & twd_r;
  assign trans_twd_add_o = in_issue_s ? slot_r : {TWD_QUEUE_ADD_WIDTH{1'b0}};

`ifdef TWD_SEQ_STATS_EN
  logic [STAT_CNT_WIDTH-1:0] twd_cnt_r;
  logic [STAT_CNT_WIDTH-1:0] stall_cnt_r;

  // Saturating count of 2D transfers completing their ISSUE handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      twd_cnt_r <= {STAT_CNT_WIDTH{1'b0}};
    end else if (done_s && twd_r && !(&twd_cnt_r)) begin
      twd_cnt_r <= twd_cnt_r + {{(STAT_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Saturating count of ALLOC cycles spent waiting for a grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= {STAT_CNT_WIDTH{1'b0}};
    end else if (in_alloc_s && !alloc_gnt_i && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + {{(STAT_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign stat_twd_cnt_o   = twd_cnt_r;
  assign stat_stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_twd_alloc_sequencer.sv
// Directed self-checking bench for twd_alloc_sequencer.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_twd_alloc_sequencer;

  localparam int TW = 64;
  localparam int QW = 2;
  localparam int QD = 4;
  localparam int AW = 2;
`ifdef TWD_SEQ_STATS_EN
  localparam int SW = 3;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_twd_i = 1'b0;
  logic [TW-1:0] cmd_dat_i = '0;
  logic [QW-1:0] cmd_twd_dat_i = '0;
  logic          alloc_req_o;
  logic          alloc_gnt_i = 1'b0;
  logic [AW-1:0] alloc_add_i = '0;
  logic          wr_req_o;
  logic [AW-1:0] wr_add_o;
  logic [QW-1:0] wr_dat_o;
  logic          trans_valid_o;
  logic          trans_ready_i = 1'b0;
  logic [TW-1:0] trans_dat_o;
  logic          trans_twd_o;
  logic [AW-1:0] trans_twd_add_o;
  logic          busy_o;
`ifdef TWD_SEQ_STATS_EN
  logic [SW-1:0] stat_twd_cnt_o;
  logic [SW-1:0] stat_stall_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  twd_alloc_sequencer #(
    .TRANS_WIDTH(TW), .TWD_QUEUE_WIDTH(QW), .TWD_QUEUE_DEPTH(QD), .TWD_QUEUE_ADD_WIDTH(AW)
`ifdef TWD_SEQ_STATS_EN
    , .STAT_CNT_WIDTH(SW)
`endif
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_twd_i(cmd_twd_i),
    .cmd_dat_i(cmd_dat_i), .cmd_twd_dat_i(cmd_twd_dat_i),
    .alloc_req_o(alloc_req_o), .alloc_gnt_i(alloc_gnt_i), .alloc_add_i(alloc_add_i),
    .wr_req_o(wr_req_o), .wr_add_o(wr_add_o), .wr_dat_o(wr_dat_o),
    .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i), .trans_dat_o(trans_dat_o),
    .trans_twd_o(trans_twd_o), .trans_twd_add_o(trans_twd_add_o), .busy_o(busy_o)
`ifdef TWD_SEQ_STATS_EN
    , .stat_twd_cnt_o(stat_twd_cnt_o), .stat_stall_cnt_o(stat_stall_cnt_o)
`endif
  );

  // All outputs except cmd_ready_o, concatenated for idle/reset checks.
  wire [1+1+AW+QW+1+TW+1+AW+1-1:0] other_outs =
    {alloc_req_o, wr_req_o, wr_add_o, wr_dat_o, trans_valid_o, trans_dat_o,
     trans_twd_o, trans_twd_add_o, busy_o};

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    tests++; if (cmd_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", cmd_ready_o); end
    tests++; if (other_outs !== '0) begin fails++; $display("FAIL reset_outs: got %h expected 0", other_outs); end
    rst_ni = 1'b1;
    tick();
    tests++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL idle_after_reset: ready=%b busy=%b expected 1/0", cmd_ready_o, busy_o); end
  endtask

  task automatic test_1d();
    logic saw_alloc;
    saw_alloc = 1'b0;
    cmd_valid_i = 1'b1; cmd_twd_i = 1'b0; cmd_dat_i = 64'h1234; cmd_twd_dat_i = 2'b11;
    trans_ready_i = 1'b1;
    tick();
    saw_alloc = saw_alloc | alloc_req_o;
    cmd_valid_i = 1'b0;
    tests++; if (trans_valid_o !== 1'b1) begin fails++; $display("FAIL 1d_valid: got %b expected 1", trans_valid_o); end
    tests++; if (trans_dat_o !== 64'h1234) begin fails++; $display("FAIL 1d_dat: got %h expected 1234", trans_dat_o); end
    tests++; if (trans_twd_o !== 1'b0 || trans_twd_add_o !== 2'd0) begin fails++; $display("FAIL 1d_twd: got twd=%b add=%0d expected 0/0", trans_twd_o, trans_twd_add_o); end
    tests++; if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL 1d_busy: ready=%b busy=%b expected 0/1", cmd_ready_o, busy_o); end
    tick();
    saw_alloc = saw_alloc | alloc_req_o | wr_req_o;
    tests++; if (trans_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin fails++; $display("FAIL 1d_done: valid=%b ready=%b expected 0/1", trans_valid_o, cmd_ready_o); end
    tests++; if (saw_alloc !== 1'b0) begin fails++; $display("FAIL 1d_no_alloc: got %b expected 0", saw_alloc); end
  endtask

  task automatic test_2d_immediate();
    cmd_valid_i = 1'b1; cmd_twd_i = 1'b1; cmd_dat_i = 64'hABCD_0000_0000_0042; cmd_twd_dat_i = 2'b10;
    alloc_gnt_i = 1'b1; alloc_add_i = 2'd3; trans_ready_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    tests++; if (alloc_req_o !== 1'b1 || cmd_ready_o !== 1'b0) begin fails++; $display("FAIL 2d_alloc: req=%b ready=%b expected 1/0", alloc_req_o, cmd_ready_o); end
    tests++; if (trans_valid_o !== 1'b0 || wr_req_o !== 1'b0) begin fails++; $display("FAIL 2d_alloc_quiet: valid=%b wr=%b expected 0/0", trans_valid_o, wr_req_o); end
    tick();
    alloc_gnt_i = 1'b0; alloc_add_i = 2'd0;
    tests++; if (wr_req_o !== 1'b1 || wr_add_o !== 2'd3 || wr_dat_o !== 2'b10) begin fails++; $display("FAIL 2d_write: req=%b add=%0d dat=%b expected 1/3/10", wr_req_o, wr_add_o, wr_dat_o); end
    tests++; if (alloc_req_o !== 1'b0) begin fails++; $display("FAIL 2d_write_noreq: got %b expected 0", alloc_req_o); end
    tick();
    tests++; if (trans_valid_o !== 1'b1 || trans_twd_o !== 1'b1 || trans_twd_add_o !== 2'd3) begin fails++; $display("FAIL 2d_issue: valid=%b twd=%b add=%0d expected 1/1/3", trans_valid_o, trans_twd_o, trans_twd_add_o); end
    tests++; if (trans_dat_o !== 64'hABCD_0000_0000_0042 || wr_req_o !== 1'b0) begin fails++; $display("FAIL 2d_issue_dat: dat=%h wr=%b expected abcd000000000042/0", trans_dat_o, wr_req_o); end
    tick();
    tests++; if (cmd_ready_o !== 1'b1 || other_outs !== '0) begin fails++; $display("FAIL 2d_idle: ready=%b outs=%h expected 1/0", cmd_ready_o, other_outs); end
  endtask

  task automatic test_queue_full();
    int req_cycles;
    logic ready_seen;
    req_cycles = 0; ready_seen = 1'b0;
    cmd_valid_i = 1'b1; cmd_twd_i = 1'b1; cmd_dat_i = 64'h77; cmd_twd_dat_i = 2'b01;
    alloc_gnt_i = 1'b0; alloc_add_i = 2'd1; trans_ready_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (alloc_req_o === 1'b1) req_cycles++;
      ready_seen = ready_seen | cmd_ready_o;
      if (i == 5) alloc_gnt_i = 1'b1;
      if (i < 6) tick();
      else break;
    end
    alloc_gnt_i = 1'b0; alloc_add_i = 2'd0;
    tests++; if (req_cycles != 6) begin fails++; $display("FAIL full_req_cycles: got %0d expected 6", req_cycles); end
    tests++; if (ready_seen !== 1'b0) begin fails++; $display("FAIL full_ready_low: got %b expected 0", ready_seen); end
    tests++; if (wr_req_o !== 1'b1 || wr_add_o !== 2'd1 || wr_dat_o !== 2'b01) begin fails++; $display("FAIL full_write: req=%b add=%0d dat=%b expected 1/1/01", wr_req_o, wr_add_o, wr_dat_o); end
    tick();
    tests++; if (trans_valid_o !== 1'b1 || trans_twd_add_o !== 2'd1 || trans_dat_o !== 64'h77) begin fails++; $display("FAIL full_issue: valid=%b add=%0d dat=%h expected 1/1/77", trans_valid_o, trans_twd_add_o, trans_dat_o); end
    tick();
    tests++; if (cmd_ready_o !== 1'b1) begin fails++; $display("FAIL full_idle: got %b expected 1", cmd_ready_o); end
  endtask

  task automatic test_backpressure();
    logic stable;
    stable = 1'b1;
    cmd_valid_i = 1'b1; cmd_twd_i = 1'b0; cmd_dat_i = 64'hDEAD_BEEF_0123_4567;
    trans_ready_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0; cmd_dat_i = 64'h0;
    for (int i = 0; i < 4; i++) begin
      if (trans_valid_o !== 1'b1 || trans_dat_o !== 64'hDEAD_BEEF_0123_4567 || cmd_ready_o !== 1'b0) stable = 1'b0;
      if (i < 3) tick();
    end
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL bp_stable: got %b expected 1", stable); end
    trans_ready_i = 1'b1;
    tick();
    tests++; if (trans_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL bp_idle: valid=%b ready=%b busy=%b expected 0/1/0", trans_valid_o, cmd_ready_o, busy_o); end
  endtask

  task automatic test_back_to_back();
    cmd_valid_i = 1'b1; cmd_twd_i = 1'b0; cmd_dat_i = 64'h1111; trans_ready_i = 1'b1;
    tick();
    tests++; if (trans_dat_o !== 64'h1111) begin fails++; $display("FAIL b2b_first: got %h expected 1111", trans_dat_o); end
    cmd_dat_i = 64'h2222;
    tick();
    tests++; if (cmd_ready_o !== 1'b1 || trans_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_gap: ready=%b valid=%b expected 1/0", cmd_ready_o, trans_valid_o); end
    tick();
    cmd_valid_i = 1'b0;
    tests++; if (trans_valid_o !== 1'b1 || trans_dat_o !== 64'h2222) begin fails++; $display("FAIL b2b_second: valid=%b dat=%h expected 1/2222", trans_valid_o, trans_dat_o); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    cmd_valid_i = 1'b1; cmd_twd_i = 1'b1; cmd_dat_i = 64'h99; cmd_twd_dat_i = 2'b11;
    alloc_gnt_i = 1'b1; alloc_add_i = 2'd2; trans_ready_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    alloc_gnt_i = 1'b0; alloc_add_i = 2'd0;
    tests++; if (wr_req_o !== 1'b1 || wr_add_o !== 2'd2) begin fails++; $display("FAIL rst_pre_write: req=%b add=%0d expected 1/2", wr_req_o, wr_add_o); end
    rst_ni = 1'b0;
    tick();
    tests++; if (cmd_ready_o !== 1'b1 || other_outs !== '0) begin fails++; $display("FAIL rst_mid_outs: ready=%b outs=%h expected 1/0", cmd_ready_o, other_outs); end
    rst_ni = 1'b1;
    cmd_valid_i = 1'b1; cmd_twd_i = 1'b0; cmd_dat_i = 64'h55;
    tick();
    cmd_valid_i = 1'b0;
    tests++; if (trans_valid_o !== 1'b1 || trans_dat_o !== 64'h55 || trans_twd_o !== 1'b0 || trans_twd_add_o !== 2'd0) begin fails++; $display("FAIL rst_recover: valid=%b dat=%h twd=%b add=%0d expected 1/55/0/0", trans_valid_o, trans_dat_o, trans_twd_o, trans_twd_add_o); end
    tick();
    tests++; if (cmd_ready_o !== 1'b1) begin fails++; $display("FAIL rst_recover_idle: got %b expected 1", cmd_ready_o); end
  endtask

`ifdef TWD_SEQ_STATS_EN
  task automatic run_2d(input int stalls);
    cmd_valid_i = 1'b1; cmd_twd_i = 1'b1; cmd_dat_i = 64'hC0; cmd_twd_dat_i = 2'b01;
    alloc_gnt_i = 1'b0; alloc_add_i = 2'd2; trans_ready_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < stalls; i++) tick();
    alloc_gnt_i = 1'b1;
    tick();
    alloc_gnt_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stats();
    rst_ni = 1'b0;
    tick();
    tests++; if (stat_twd_cnt_o !== 3'd0 || stat_stall_cnt_o !== 3'd0) begin fails++; $display("FAIL stats_reset: twd=%0d stall=%0d expected 0/0", stat_twd_cnt_o, stat_stall_cnt_o); end
    rst_ni = 1'b1;
    run_2d(1);
    run_2d(1);
    run_2d(0);
    tests++; if (stat_twd_cnt_o !== 3'd3 || stat_stall_cnt_o !== 3'd2) begin fails++; $display("FAIL stats_count: twd=%0d stall=%0d expected 3/2", stat_twd_cnt_o, stat_stall_cnt_o); end
    for (int k = 0; k < 5; k++) run_2d(2);
    tests++; if (stat_twd_cnt_o !== 3'd7 || stat_stall_cnt_o !== 3'd7) begin fails++; $display("FAIL stats_saturate: twd=%0d stall=%0d expected 7/7", stat_twd_cnt_o, stat_stall_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_1d();
    test_2d_immediate();
    test_queue_full();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_write();
`ifdef TWD_SEQ_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
